// File: rtl/cs_sequencer.sv
// cs_sequencer: boots the control store from ROM, then sequences the micro-PC with a return stack
module cs_sequencer #(
    parameter int                    ADDR_WIDTH  = 8,
    parameter int                    DATA_WIDTH  = 64,
    parameter int                    STACK_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] HALT_ADDR   = 8'hFE
) (
    input  logic                  clk,
    input  logic                  _reset,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_we,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    input  logic [2:0]            seq_op,
    input  logic [ADDR_WIDTH-1:0] jump_addr,
    input  logic [ADDR_WIDTH-1:0] dispatch_addr,
    input  logic                  cond,
    input  logic                  stall,
    output logic [ADDR_WIDTH-1:0] upc,
    output logic [DATA_WIDTH-1:0] uop,
    output logic                  cs_ready,
    output logic                  halted,
    output logic                  stack_err
);
    localparam int SPW = $clog2(STACK_DEPTH + 1);
    localparam int SIW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    typedef enum logic [1:0] {S_COPY, S_RUN, S_HALT} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] copy_cnt_q, copy_cnt_d;
    logic [ADDR_WIDTH-1:0] upc_q, upc_d;
    logic [SPW-1:0]        sp_q, sp_d;
    logic                  cs_ready_q, cs_ready_d;
    logic                  stack_err_q, stack_err_d;
    logic [ADDR_WIDTH-1:0] stack_q [STACK_DEPTH];
    logic [ADDR_WIDTH-1:0] stack_d [STACK_DEPTH];
    logic [ADDR_WIDTH-1:0] upc_inc;
    logic [SPW-1:0]        sp_dec;

    assign upc_inc   = upc_q + ADDR_WIDTH'(1);
    assign sp_dec    = sp_q - SPW'(1);
    assign rom_addr  = (state_q == S_COPY) ? copy_cnt_q : '0;
    assign ram_addr  = (state_q == S_COPY) ? copy_cnt_q : upc_q;
    assign ram_we    = (state_q == S_COPY);
    assign ram_wdata = rom_data;
    assign uop       = (state_q == S_COPY) ? '0 : ram_rdata;
    assign upc       = upc_q;
    assign cs_ready  = cs_ready_q;
    assign stack_err = stack_err_q;
    assign halted    = (state_q == S_HALT) | ((state_q == S_RUN) & (upc_q == HALT_ADDR));

    // Next-state: boot copy, micro-PC selection and stack push/pop; stack faults freeze the machine
    always_comb begin
        state_d     = state_q;
        copy_cnt_d  = copy_cnt_q;
        upc_d       = upc_q;
        sp_d        = sp_q;
        stack_err_d = stack_err_q;
        stack_d     = stack_q;
        case (state_q)
            S_COPY: begin
                copy_cnt_d = copy_cnt_q + ADDR_WIDTH'(1);
                if (&copy_cnt_q) begin
                    state_d = S_RUN;
                    upc_d   = '0;
                end
            end
            S_RUN: begin
                if (upc_q == HALT_ADDR) begin
                    state_d = S_HALT;
                end else if (!stall) begin
                    case (seq_op)
                        3'b001: upc_d = jump_addr;
                        3'b010: upc_d = cond ? jump_addr : upc_inc;
                        3'b011: begin
                            if (sp_q == SPW'(STACK_DEPTH)) begin
                                stack_err_d = 1'b1;
                                state_d     = S_HALT;
                            end else begin
                                stack_d[sp_q[SIW-1:0]] = upc_inc;
                                sp_d  = sp_q + SPW'(1);
                                upc_d = jump_addr;
                            end
                        end
                        3'b100: begin
                            if (sp_q == '0) begin
                                stack_err_d = 1'b1;
                                state_d     = S_HALT;
                            end else begin
                                upc_d = stack_q[sp_dec[SIW-1:0]];
                                sp_d  = sp_dec;
                            end
                        end
                        3'b101: upc_d = dispatch_addr;
                        default: upc_d = upc_inc;
                    endcase
                end
            end
            default: ;
        endcase
        cs_ready_d = (state_d != S_COPY);
    end

    // State registers; stack contents survive reset, only the pointer clears
    always_ff @(posedge clk) begin
        if (!_reset) begin
            state_q     <= S_COPY;
            copy_cnt_q  <= '0;
            upc_q       <= '0;
            sp_q        <= '0;
            cs_ready_q  <= 1'b0;
            stack_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            copy_cnt_q  <= copy_cnt_d;
            upc_q       <= upc_d;
            sp_q        <= sp_d;
            cs_ready_q  <= cs_ready_d;
            stack_err_q <= stack_err_d;
        end
        stack_q <= stack_d;
    end
endmodule

// File: tb/tb_cs_sequencer.sv
// tb_cs_sequencer: scenario tasks with a scoreboard of expected micro-PC / status per cycle
module tb_cs_sequencer;
    localparam logic [2:0] NX = 3'd0, JP = 3'd1, JC = 3'd2, CL = 3'd3, RT = 3'd4, DP = 3'd5;

    typedef struct {
        logic [2:0] op;
        logic [7:0] ja;
        logic [7:0] da;
        logic [1:0] cs;
        logic [7:0] upc;
        logic [1:0] he;
    } row_t;

    logic        clk;
    logic        _reset;
    logic [7:0]  rom_addr, ram_addr, jump_addr, dispatch_addr, upc;
    logic [63:0] rom_data, ram_wdata, ram_rdata, uop;
    logic        ram_we, cond, stall, cs_ready, halted, stack_err;
    logic [2:0]  seq_op;
    logic [63:0] mem [256];

    row_t       sq[$];
    logic [7:0] aq[$];
    int         n_cmp = 0;
    int         n_bad = 0;

    cs_sequencer dut (
        .clk(clk), ._reset(_reset), .rom_addr(rom_addr), .rom_data(rom_data),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .seq_op(seq_op), .jump_addr(jump_addr), .dispatch_addr(dispatch_addr), .cond(cond),
        .stall(stall), .upc(upc), .uop(uop), .cs_ready(cs_ready), .halted(halted),
        .stack_err(stack_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign rom_data  = 64'(rom_addr) * 64'd3;
    assign ram_rdata = mem[ram_addr];
    always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_wdata;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    task automatic issue(input row_t r);
        seq_op        = r.op;
        jump_addr     = r.ja;
        dispatch_addr = r.da;
        {cond, stall} = r.cs;
        sq.push_back(r);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        _reset = 1'b0;
        seq_op = NX;
        stall  = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if ({cs_ready, halted, stack_err, upc, ram_we, ram_addr, uop} !== {3'b000, 8'h00, 1'b1, 8'h00, 64'd0}) begin
            n_bad++;
            $display("FAIL reset: rdy=%b h=%b err=%b upc=%h we=%b addr=%h uop=%h, want 0 0 0 00 1 00 0",
                     cs_ready, halted, stack_err, upc, ram_we, ram_addr, uop);
        end
        _reset = 1'b1;
    endtask

    task automatic test_copy(input int n);
        logic [7:0] a;
        for (int k = 0; k < n; k++) begin
            aq.push_back(8'(k));
            a = aq.pop_front();
            n_cmp++;
            if ({ram_we, ram_addr, ram_wdata, cs_ready, halted, uop} !== {1'b1, a, 64'(a) * 64'd3, 2'b00, 64'd0}) begin
                n_bad++;
                $display("FAIL copy[%0d]: we=%b addr=%h wdata=%h rdy=%b h=%b uop=%h, want we=1 addr=%h wdata=%h rdy=0 h=0 uop=0",
                         k, ram_we, ram_addr, ram_wdata, cs_ready, halted, uop, a, 64'(a) * 64'd3);
            end
            @(posedge clk);
            #1;
        end
        if (n == 256) begin
            n_cmp++;
            if ({cs_ready, ram_we, halted, stack_err, upc, uop, mem[8'hFF]} !== {4'b1000, 8'h00, 64'd0, 64'h2FD}) begin
                n_bad++;
                $display("FAIL copy_done: rdy=%b we=%b h=%b err=%b upc=%h uop=%h ram[ff]=%h, want 1 0 0 0 00 0 2fd",
                         cs_ready, ram_we, halted, stack_err, upc, uop, mem[8'hFF]);
            end
        end
    endtask

    task automatic test_branch();
        row_t t [8] = '{
            '{JP, 8'h40, 8'h00, 2'b00, 8'h40, 2'b00},
            '{JC, 8'h90, 8'h00, 2'b00, 8'h41, 2'b00},
            '{JC, 8'h90, 8'h00, 2'b10, 8'h90, 2'b00},
            '{DP, 8'h00, 8'h23, 2'b00, 8'h23, 2'b00},
            '{JP, 8'hFF, 8'h00, 2'b00, 8'hFF, 2'b00},
            '{NX, 8'h00, 8'h00, 2'b00, 8'h00, 2'b00},
            '{3'd6, 8'h77, 8'h00, 2'b10, 8'h01, 2'b00},
            '{3'd7, 8'h77, 8'h00, 2'b10, 8'h02, 2'b00}};
        row_t x;
        foreach (t[i]) begin
            issue(t[i]);
            x = sq.pop_front();
            n_cmp++;
            if ({upc, halted, stack_err, cs_ready, uop} !== {x.upc, x.he, 1'b1, 64'(x.upc) * 64'd3}) begin
                n_bad++;
                $display("FAIL branch[%0d]: upc=%h h=%b err=%b rdy=%b uop=%h, want upc=%h h/err=%b rdy=1",
                         i, upc, halted, stack_err, cs_ready, uop, x.upc, x.he);
            end
        end
    endtask

    task automatic test_stall();
        row_t t [5] = '{
            '{JP, 8'h55, 8'h00, 2'b01, 8'h02, 2'b00},
            '{JP, 8'h55, 8'h00, 2'b01, 8'h02, 2'b00},
            '{JP, 8'h55, 8'h00, 2'b01, 8'h02, 2'b00},
            '{CL, 8'h66, 8'h00, 2'b01, 8'h02, 2'b00},
            '{JP, 8'h55, 8'h00, 2'b00, 8'h55, 2'b00}};
        row_t x;
        foreach (t[i]) begin
            issue(t[i]);
            x = sq.pop_front();
            n_cmp++;
            if ({upc, halted, stack_err, cs_ready, uop} !== {x.upc, x.he, 1'b1, 64'(x.upc) * 64'd3}) begin
                n_bad++;
                $display("FAIL stall[%0d]: upc=%h h=%b err=%b rdy=%b uop=%h, want upc=%h h/err=%b rdy=1",
                         i, upc, halted, stack_err, cs_ready, uop, x.upc, x.he);
            end
        end
    endtask

    task automatic test_stack();
        row_t t [7] = '{
            '{JP, 8'h10, 8'h00, 2'b00, 8'h10, 2'b00},
            '{CL, 8'h80, 8'h00, 2'b00, 8'h80, 2'b00},
            '{CL, 8'h90, 8'h00, 2'b00, 8'h90, 2'b00},
            '{NX, 8'h00, 8'h00, 2'b00, 8'h91, 2'b00},
            '{RT, 8'h00, 8'h00, 2'b00, 8'h81, 2'b00},
            '{RT, 8'h00, 8'h00, 2'b00, 8'h11, 2'b00},
            '{NX, 8'h00, 8'h00, 2'b00, 8'h12, 2'b00}};
        row_t x;
        foreach (t[i]) begin
            issue(t[i]);
            x = sq.pop_front();
            n_cmp++;
            if ({upc, halted, stack_err, cs_ready, uop} !== {x.upc, x.he, 1'b1, 64'(x.upc) * 64'd3}) begin
                n_bad++;
                $display("FAIL stack[%0d]: upc=%h h=%b err=%b rdy=%b uop=%h, want upc=%h h/err=%b rdy=1",
                         i, upc, halted, stack_err, cs_ready, uop, x.upc, x.he);
            end
        end
    endtask

    task automatic test_halt();
        row_t t [3] = '{
            '{JP, 8'hFE, 8'h00, 2'b00, 8'hFE, 2'b10},
            '{JP, 8'h00, 8'h00, 2'b00, 8'hFE, 2'b10},
            '{RT, 8'h00, 8'h00, 2'b01, 8'hFE, 2'b10}};
        row_t x;
        foreach (t[i]) begin
            issue(t[i]);
            x = sq.pop_front();
            n_cmp++;
            if ({upc, halted, stack_err, cs_ready, ram_we, uop} !== {x.upc, x.he, 2'b10, 64'(x.upc) * 64'd3}) begin
                n_bad++;
                $display("FAIL halt[%0d]: upc=%h h=%b err=%b rdy=%b we=%b uop=%h, want upc=%h h/err=%b rdy=1 we=0",
                         i, upc, halted, stack_err, cs_ready, ram_we, uop, x.upc, x.he);
            end
        end
    endtask

    task automatic test_overflow();
        row_t t [7] = '{
            '{JP, 8'h20, 8'h00, 2'b00, 8'h20, 2'b00},
            '{CL, 8'h30, 8'h00, 2'b00, 8'h30, 2'b00},
            '{CL, 8'h40, 8'h00, 2'b00, 8'h40, 2'b00},
            '{CL, 8'h50, 8'h00, 2'b00, 8'h50, 2'b00},
            '{CL, 8'h60, 8'h00, 2'b00, 8'h60, 2'b00},
            '{CL, 8'h70, 8'h00, 2'b00, 8'h60, 2'b11},
            '{JP, 8'h00, 8'h00, 2'b00, 8'h60, 2'b11}};
        row_t x;
        foreach (t[i]) begin
            issue(t[i]);
            x = sq.pop_front();
            n_cmp++;
            if ({upc, halted, stack_err, cs_ready, uop} !== {x.upc, x.he, 1'b1, 64'(x.upc) * 64'd3}) begin
                n_bad++;
                $display("FAIL overflow[%0d]: upc=%h h=%b err=%b rdy=%b uop=%h, want upc=%h h/err=%b rdy=1",
                         i, upc, halted, stack_err, cs_ready, uop, x.upc, x.he);
            end
        end
    endtask

    task automatic test_reset_mid();
        row_t t [3] = '{
            '{CL, 8'h30, 8'h00, 2'b00, 8'h30, 2'b00},
            '{CL, 8'h40, 8'h00, 2'b00, 8'h40, 2'b00},
            '{RT, 8'h00, 8'h00, 2'b00, 8'h00, 2'b11}};
        row_t x;
        test_reset();
        test_copy(8'h37);
        test_reset();
        test_copy(256);
        for (int i = 0; i < 3; i++) begin
            if (i == 2) begin
                test_reset();
                test_copy(256);
            end
            issue(t[i]);
            x = sq.pop_front();
            n_cmp++;
            if ({upc, halted, stack_err, cs_ready, uop} !== {x.upc, x.he, 1'b1, 64'(x.upc) * 64'd3}) begin
                n_bad++;
                $display("FAIL reset_mid[%0d]: upc=%h h=%b err=%b rdy=%b uop=%h, want upc=%h h/err=%b rdy=1",
                         i, upc, halted, stack_err, cs_ready, uop, x.upc, x.he);
            end
        end
    endtask

    initial begin
        _reset        = 1'b0;
        seq_op        = NX;
        jump_addr     = 8'h00;
        dispatch_addr = 8'h00;
        cond          = 1'b0;
        stall         = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_copy(256);
        test_branch();
        test_stall();
        test_stack();
        test_halt();
        test_reset();
        test_copy(256);
        test_overflow();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
